// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with press/release debounce and two-digit shift register.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-strobe a held key every REPEAT_N scan ticks.
module keypad_scan_ctrl #(
    parameter int TICK_W     = 16,
    parameter int DEBOUNCE_N = 4,
    parameter int REPEAT_N   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] r_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    localparam int CW = $clog2(DEBOUNCE_N + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_N);
    // Entry {row, col} holds the legend of that key; row 0 col 0 sits in the low nibble.
    localparam logic [63:0] KEYMAP = {4'hD, 4'hF, 4'h0, 4'hE,
                                      4'hC, 4'h9, 4'h8, 4'h7,
                                      4'hB, 4'h6, 4'h5, 4'h4,
                                      4'hA, 4'h3, 4'h2, 4'h1};

    state_t          state, n_state;
    logic [TICK_W-1:0] pre;
    logic            tick;
    logic [3:0]      c1, csync;
    logic [1:0]      row, n_row, cidx;
    logic [3:0]      lat, n_lat, code;
    logic [CW-1:0]   cnt, n_cnt;
    logic            fire;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_N + 1);
    localparam logic [RW-1:0] RMAX = RW'(REPEAT_N);
    logic [RW-1:0]   rpt, n_rpt;
`endif

    assign tick = &pre;
    assign cidx = !lat[0] ? 2'd0 : !lat[1] ? 2'd1 : !lat[2] ? 2'd2 : 2'd3;
    assign code = KEYMAP[{row, cidx, 2'b00} +: 4];

    // State, scan position, counters, synchronizer and the registered key outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            pre       <= '0;
            c1        <= 4'hF;
            csync     <= 4'hF;
            row       <= 2'd0;
            lat       <= 4'hF;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            digit_hi  <= 4'h0;
            digit_lo  <= 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt       <= '0;
`endif
        end else begin
            state     <= n_state;
            pre       <= pre + 1'b1;
            c1        <= col;
            csync     <= c1;
            row       <= n_row;
            lat       <= n_lat;
            cnt       <= n_cnt;
            key_valid <= fire;
            key_code  <= fire ? code : key_code;
            digit_hi  <= fire ? digit_lo : digit_hi;
            digit_lo  <= fire ? code : digit_lo;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt       <= n_rpt;
`endif
        end
    end

    // Next-state logic: everything advances only on a scan tick.
    always_comb begin
        n_state = state;
        n_row   = row;
        n_lat   = lat;
        n_cnt   = cnt;
        fire    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        n_rpt   = rpt;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if ($countones(~csync) != 1) begin
                        n_row = row + 2'd1;
                    end else begin
                        n_lat   = csync;
                        n_cnt   = CW'(1);
                        n_state = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (csync != lat) begin
                        n_state = SCAN;
                    end else if (cnt >= CMAX - 1'b1) begin
                        n_cnt   = CMAX;
                        n_state = HELD;
                        fire    = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                        n_rpt   = '0;
`endif
                    end else begin
                        n_cnt = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (csync == 4'hF) begin
                        n_cnt   = CW'(1);
                        n_state = RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
                    end else if (rpt >= RMAX - 1'b1) begin
                        n_rpt = '0;
                        fire  = 1'b1;
                    end else begin
                        n_rpt = rpt + 1'b1;
`endif
                    end
                end
                RELEASE: begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    n_rpt = '0;
`endif
                    if (csync != 4'hF) begin
                        n_state = HELD;
                    end else if (cnt >= CMAX - 1'b1) begin
                        n_cnt   = CMAX;
                        n_row   = row + 2'd1;
                        n_state = SCAN;
                    end else begin
                        n_cnt = cnt + 1'b1;
                    end
                end
                default: n_state = SCAN;
            endcase
        end
    end

    // Outputs decoded from the current state and row.
    always_comb begin
        r_sel    = ~(4'b0001 << row);
        key_held = (state == HELD) || (state == RELEASE);
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: randomized keypad presses against a key-level reference model with a strobe scoreboard.
module tb_keypad_scan_ctrl;
    localparam int TW = 3;
    localparam int TC = 8;
    localparam int DN = 4;
    localparam int RN = 32;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] hi;
        logic [3:0] lo;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  col;
    logic [3:0]  r_sel, key_code, digit_hi, digit_lo;
    logic        key_valid, key_held;
    logic [15:0] pressed = '0;
    logic [3:0]  exp_hi = 4'h0, exp_lo = 4'h0;
    logic        prev_valid = 1'b0;
    logic [3:0]  kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};
    ev_t         q[$];
    int          total = 0, bad = 0, strobes = 0;

    keypad_scan_ctrl #(.TICK_W(TW), .DEBOUNCE_N(DN), .REPEAT_N(RN)) dut (
        .clk(clk), .reset(reset), .col(col), .r_sel(r_sel), .key_code(key_code),
        .key_valid(key_valid), .key_held(key_held), .digit_hi(digit_hi), .digit_lo(digit_lo)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its column low while its row is selected.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !r_sel[r]) col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_key(input int idx);
        exp_hi = exp_lo;
        exp_lo = kmap[idx];
        q.push_back(ev_t'{code: kmap[idx], hi: exp_hi, lo: exp_lo});
    endtask

    task automatic press(input int idx, input int hold, input int gap);
        pressed[idx] = 1'b1;
        cyc(hold * TC);
        pressed = '0;
        cyc(gap * TC);
    endtask

    task automatic wait_held();
        for (int i = 0; i < 400 && !key_held; i++) cyc(1);
        check("held_seen", key_held, 1);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected key event.
    always @(negedge clk) begin : mon
        ev_t e;
        if (reset && key_valid) begin
            strobes++;
            check("held_with_strobe", key_held, 1);
            check("no_back_to_back", prev_valid, 0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got code %0h expected no strobe", key_code);
            end else begin
                e = q.pop_front();
                check("key_code", key_code, e.code);
                check("digit_hi", digit_hi, e.hi);
                check("digit_lo", digit_lo, e.lo);
            end
        end
        prev_valid = reset && key_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [3:0] r0;
        cyc(3);
        check("rst_r_sel", r_sel, 4'hE);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_held", key_held, 0);
        check("rst_digit_hi", digit_hi, 0);
        check("rst_digit_lo", digit_lo, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1 check("scan0", r_sel, 4'hE);
        cyc(1);
        check("scan1", r_sel, 4'hD);
        cyc(TC);
        check("scan2", r_sel, 4'hB);
        cyc(TC);
        check("scan3", r_sel, 4'h7);
        cyc(TC);
        check("scan4", r_sel, 4'hE);
        expect_key(5);
        press(5, 20, 12);
        expect_key(10);
        press(10, 20, 12);
        for (int i = 0; i < 64 && r_sel != 4'hD; i++) cyc(1);
        check("reach_row1", r_sel, 4'hD);
        s0 = strobes;
        for (int i = 0; i < 3; i++) begin
            pressed[5] = ~pressed[5];
            cyc(TC);
        end
        pressed = '0;
        cyc(6 * TC);
        check("bounce_no_strobe", strobes - s0, 0);
        r0 = r_sel;
        cyc(TC);
        check("scan_resumes", r_sel, {r0[2:0], r0[3]});
        s0 = strobes;
        pressed = 16'h0030;
        cyc(20 * TC);
        pressed = '0;
        cyc(12 * TC);
        check("two_keys_ignored", strobes - s0, 0);
        s0 = strobes;
        expect_key(11);
        pressed[11] = 1'b1;
        wait_held();
        cyc(5 * TC);
        pressed = '0;
        cyc(2 * TC);
        pressed[11] = 1'b1;
        cyc(10 * TC);
        pressed = '0;
        cyc(12 * TC);
        check("glitch_one_strobe", strobes - s0, 1);
        check("released", key_held, 0);
        s0 = strobes;
        expect_key(3);
`ifdef KEYPAD_AUTOREPEAT_EN
        expect_key(3);
        expect_key(3);
        press(3, 90, 12);
        check("repeat_strobes", strobes - s0, 3);
`else
        press(3, 90, 12);
        check("repeat_strobes", strobes - s0, 1);
`endif
        for (int n = 0; n < 8; n++) begin
            int idx;
            idx = int'($urandom_range(0, 15));
            expect_key(idx);
            press(idx, int'($urandom_range(12, 25)), int'($urandom_range(10, 16)));
        end
        expect_key(6);
        pressed[6] = 1'b1;
        wait_held();
        cyc(3 * TC);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_r_sel", r_sel, 4'hE);
        check("mid_rst_key_code", key_code, 0);
        check("mid_rst_key_valid", key_valid, 0);
        check("mid_rst_key_held", key_held, 0);
        check("mid_rst_digit_hi", digit_hi, 0);
        check("mid_rst_digit_lo", digit_lo, 0);
        exp_hi = 4'h0;
        exp_lo = 4'h0;
        pressed = '0;
        cyc(4);
        @(negedge clk);
        reset = 1'b1;
        expect_key(5);
        press(5, 20, 12);
        for (int i = 0; i < 100 && q.size() != 0; i++) cyc(1);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
